// File: rtl/xpb_lut_gen.sv
`default_nettype none
// ============================================================================
// Module   : xpb_lut_gen
// Purpose  : Loads one WIDTH-bit base value, fills a 2^SEL_W entry table with
//            k*base (k = 0..2^SEL_W-1) by repeated addition, then serves
//            LANES independent registered lookups per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module xpb_lut_gen #(
    parameter int WIDTH = 1024,
    parameter int SEL_W = 5,
    parameter int LANES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_valid,
    input  logic [WIDTH-1:0]         base_in,
    output logic                     busy,
    output logic                     ready,
    output logic                     done,
    output logic                     overflow,
    input  logic [LANES-1:0]         sel_valid,
    input  logic [LANES*SEL_W-1:0]   sel_in,
    output logic [LANES-1:0]         data_valid,
    output logic [LANES*WIDTH-1:0]   data_out
);

    localparam int               DEPTH  = 1 << SEL_W;
    localparam logic [SEL_W-1:0] C_LAST = {SEL_W{1'b1}};
    localparam logic [SEL_W-1:0] C_ONE  = {{(SEL_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_last;

    logic [WIDTH-1:0]   r_base;
    logic [WIDTH-1:0]   r_acc;
    logic [SEL_W-1:0]   r_cnt;
    logic               r_ovf;
    logic               r_done;
    logic [WIDTH:0]     w_sum;

    // Table storage: one write port (fill), LANES read ports; never reset,
    // reads are gated by the READY state instead.
    logic [WIDTH-1:0]   r_table [DEPTH];

    logic [WIDTH-1:0]   r_dout  [LANES];
    logic [LANES-1:0]   r_dvalid;

    // Extra MSB of the sum captures the carry out of the WIDTH-bit accumulator.
    assign w_sum = {1'b0, r_acc} + {1'b0, r_base};

    // Next-state logic; a load is honoured only outside of a fill.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (load_valid) begin
                    w_state_nxt = S_FILL;
                    w_accept    = 1'b1;
                end
            end
            S_FILL: begin
                if (r_cnt == C_LAST) begin
                    w_state_nxt = S_READY;
                    w_last      = 1'b1;
                end
            end
            S_READY: begin
                if (load_valid) begin
                    w_state_nxt = S_FILL;
                    w_accept    = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Accumulator, step counter, sticky overflow and the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_base <= base_in;
                r_acc  <= '0;
                r_cnt  <= '0;
                r_ovf  <= 1'b0;
            end else if (r_state == S_FILL) begin
                r_acc  <= w_sum[WIDTH-1:0];
                r_ovf  <= r_ovf | w_sum[WIDTH];
                r_cnt  <= r_cnt + C_ONE;
            end
        end
    end

    // Table write: entry r_cnt receives r_cnt*base, held in the accumulator.
    always_ff @(posedge clk) begin
        if (r_state == S_FILL) begin
            r_table[r_cnt] <= r_acc;
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            // Per-lane registered lookup, served only from a complete table.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dout[gi]   <= '0;
                    r_dvalid[gi] <= 1'b0;
                end else if (sel_valid[gi] && (r_state == S_READY)) begin
                    r_dout[gi]   <= r_table[sel_in[gi*SEL_W +: SEL_W]];
                    r_dvalid[gi] <= 1'b1;
                end else begin
                    r_dout[gi]   <= '0;
                    r_dvalid[gi] <= 1'b0;
                end
            end
            assign data_out[gi*WIDTH +: WIDTH] = r_dout[gi];
        end
    endgenerate

    assign data_valid = r_dvalid;
    assign busy       = (r_state == S_FILL);
    assign ready      = (r_state == S_READY);
    assign done       = r_done;
    assign overflow   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_xpb_lut_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_xpb_lut_gen
// Purpose  : Self-checking bench for xpb_lut_gen: a small 16/3/2 instance for
//            directed, table-driven and randomized checks, and a default
//            1024/5/2 instance for a full-width table check.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xpb_lut_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Small instance signals
    logic        s_load = 1'b0;
    logic [15:0] s_base = '0;
    logic        s_busy, s_ready, s_done, s_ovf;
    logic [1:0]  s_selv = '0;
    logic [5:0]  s_sel  = '0;
    logic [1:0]  s_dv;
    logic [31:0] s_do;

    // Default-size instance signals
    logic          b_load = 1'b0;
    logic [1023:0] b_base = '0;
    logic          b_busy, b_ready, b_done, b_ovf;
    logic [1:0]    b_selv = '0;
    logic [9:0]    b_sel  = '0;
    logic [1:0]    b_dv;
    logic [2047:0] b_do;

    xpb_lut_gen #(.WIDTH(16), .SEL_W(3), .LANES(2)) u_small (
        .clk(clk), .rst_n(rst_n), .load_valid(s_load), .base_in(s_base),
        .busy(s_busy), .ready(s_ready), .done(s_done), .overflow(s_ovf),
        .sel_valid(s_selv), .sel_in(s_sel), .data_valid(s_dv), .data_out(s_do)
    );

    xpb_lut_gen u_big (
        .clk(clk), .rst_n(rst_n), .load_valid(b_load), .base_in(b_base),
        .busy(b_busy), .ready(b_ready), .done(b_done), .overflow(b_ovf),
        .sel_valid(b_selv), .sel_in(b_sel), .data_valid(b_dv), .data_out(b_do)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [1023:0] a, input logic [1023:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s act=%h..%h exp=%h..%h", nm, a[1023:896], a[127:0],
                     e[1023:896], e[127:0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: entry k of a WIDTH=16 table is k*base modulo 2^16.
    function automatic logic [15:0] ref_s(input logic [15:0] base, input int k);
        logic [31:0] p;
        p = 32'(base) * 32'(k);
        return p[15:0];
    endfunction

    // Reference: a fill overflows when the largest accumulated sum, 8*base,
    // does not fit in 16 bits.
    function automatic logic ref_ovf_s(input logic [15:0] base);
        logic [31:0] p;
        p = 32'(base) * 32'd8;
        return (p[31:16] != 16'd0);
    endfunction

    task automatic load_s(input logic [15:0] b);
        s_base = b;
        s_load = 1'b1;
        step();
        s_load = 1'b0;
    endtask

    // Steps until ready; n counts cycles since the accepting edge and busy
    // cycles are tallied. During the fill no lookup may be answered.
    task automatic wait_ready_s(output int n, output int nbusy);
        n = 0;
        nbusy = 0;
        while (!s_ready && n < 40) begin
            if (s_busy) nbusy++;
            chk("fill_dv", 1024'(s_dv), 1024'(0));
            step();
            n++;
        end
    endtask

    typedef struct {
        logic [15:0] base;
        logic [2:0]  sel0;
        logic [2:0]  sel1;
        logic [15:0] exp0;
        logic [15:0] exp1;
        logic        ovf;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int n, nb;
        logic [15:0]   rb;
        logic [1:0]    sv;
        logic [2:0]    r0, r1;
        logic [1023:0] bb;

        vecs[0] = '{16'h0123, 3'd5, 3'd7, 16'h05AF, 16'h07F5, 1'b0};
        vecs[1] = '{16'h2500, 3'd6, 3'd7, 16'hDE00, 16'h0300, 1'b1};
        vecs[2] = '{16'h0001, 3'd7, 3'd0, 16'h0007, 16'h0000, 1'b0};
        vecs[3] = '{16'hFFFF, 3'd1, 3'd2, 16'hFFFF, 16'hFFFE, 1'b1};
        vecs[4] = '{16'h0002, 3'd3, 3'd3, 16'h0006, 16'h0006, 1'b0};

        // Reset state
        #2;
        chk("rst_busy",  1024'(s_busy),  1024'(0));
        chk("rst_ready", 1024'(s_ready), 1024'(0));
        chk("rst_done",  1024'(s_done),  1024'(0));
        chk("rst_ovf",   1024'(s_ovf),   1024'(0));
        chk("rst_dv",    1024'(s_dv),    1024'(0));
        chk("rst_do",    1024'(s_do),    1024'(0));
        #2 rst_n = 1'b1;
        step();

        // Table-driven fills and lookups
        foreach (vecs[i]) begin
            s_selv = 2'b00;
            load_s(vecs[i].base);
            chk("load_busy", 1024'(s_busy), 1024'(1));
            wait_ready_s(n, nb);
            chk("fill_latency", 1024'(n), 1024'(8));
            chk("busy_cycles", 1024'(nb), 1024'(8));
            chk("done_rise", 1024'(s_done), 1024'(1));
            chk("busy_low", 1024'(s_busy), 1024'(0));
            chk("ovf", 1024'(s_ovf), 1024'(vecs[i].ovf));
            s_selv = 2'b11;
            s_sel  = {vecs[i].sel1, vecs[i].sel0};
            step();
            chk("done_pulse", 1024'(s_done), 1024'(0));
            chk("vec_dv", 1024'(s_dv), 1024'(2'b11));
            chk("vec_lane0", 1024'(s_do[15:0]),  1024'(vecs[i].exp0));
            chk("vec_lane1", 1024'(s_do[31:16]), 1024'(vecs[i].exp1));
        end

        // Lookups and a second load during a fill are both ignored
        s_selv = 2'b00;
        load_s(16'h0040);
        s_selv = 2'b11;
        s_sel  = {3'd1, 3'd7};
        n = 0;
        while (!s_ready && n < 40) begin
            chk("midfill_dv", 1024'(s_dv), 1024'(0));
            chk("midfill_do", 1024'(s_do), 1024'(0));
            if (n == 2) begin
                s_base = 16'h1111;
                s_load = 1'b1;
            end else begin
                s_load = 1'b0;
            end
            step();
            n++;
        end
        s_load = 1'b0;
        chk("midfill_latency", 1024'(n), 1024'(8));
        step();
        chk("midfill_lane0", 1024'(s_do[15:0]),  1024'(16'h01C0));
        chk("midfill_lane1", 1024'(s_do[31:16]), 1024'(16'h0040));

        // Load together with a lookup in READY: lookup sees the old table
        s_base = 16'h0002;
        s_load = 1'b1;
        s_selv = 2'b01;
        s_sel  = {3'd0, 3'd3};
        step();
        s_load = 1'b0;
        chk("ovl_dv", 1024'(s_dv), 1024'(2'b01));
        chk("ovl_old", 1024'(s_do[15:0]), 1024'(16'h00C0));
        chk("ovl_lane1_zero", 1024'(s_do[31:16]), 1024'(0));
        chk("ovl_ready_low", 1024'(s_ready), 1024'(0));
        step();
        chk("ovl_not_served", 1024'(s_dv), 1024'(0));
        n = 1;
        while (!s_ready && n < 40) begin
            step();
            n++;
        end
        chk("ovl_latency", 1024'(n), 1024'(8));
        step();
        chk("ovl_new", 1024'(s_do[15:0]), 1024'(16'h0006));

        // Asynchronous reset mid-fill
        s_selv = 2'b00;
        load_s(16'hFFFF);
        for (int i = 0; i < 4; i++) step();
        chk("pre_rst_busy", 1024'(s_busy), 1024'(1));
        chk("pre_rst_ovf",  1024'(s_ovf),  1024'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy",  1024'(s_busy),  1024'(0));
        chk("arst_ready", 1024'(s_ready), 1024'(0));
        chk("arst_done",  1024'(s_done),  1024'(0));
        chk("arst_ovf",   1024'(s_ovf),   1024'(0));
        chk("arst_dv",    1024'(s_dv),    1024'(0));
        chk("arst_do",    1024'(s_do),    1024'(0));
        #1 rst_n = 1'b1;
        s_selv = 2'b11;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("post_rst_ready", 1024'(s_ready), 1024'(0));
            chk("post_rst_dv", 1024'(s_dv), 1024'(0));
        end
        s_selv = 2'b00;
        load_s(16'h0003);
        wait_ready_s(n, nb);
        chk("post_rst_latency", 1024'(n), 1024'(8));
        s_selv = 2'b11;
        s_sel  = {3'd5, 3'd2};
        step();
        chk("post_rst_lane0", 1024'(s_do[15:0]),  1024'(16'h0006));
        chk("post_rst_lane1", 1024'(s_do[31:16]), 1024'(16'h000F));

        // Randomized fills and lookups against the reference
        for (int t = 0; t < 6; t++) begin
            s_selv = 2'b00;
            rb = 16'($urandom_range(0, 16'hFFFF));
            load_s(rb);
            wait_ready_s(n, nb);
            chk("rnd_latency", 1024'(n), 1024'(8));
            chk("rnd_ovf", 1024'(s_ovf), 1024'(ref_ovf_s(rb)));
            for (int c = 0; c < 12; c++) begin
                sv = 2'($urandom_range(0, 3));
                r0 = 3'($urandom_range(0, 7));
                r1 = 3'($urandom_range(0, 7));
                s_selv = sv;
                s_sel  = {r1, r0};
                step();
                chk("rnd_dv", 1024'(s_dv), 1024'(sv));
                chk("rnd_lane0", 1024'(s_do[15:0]),
                    1024'(sv[0] ? ref_s(rb, int'(r0)) : 16'h0000));
                chk("rnd_lane1", 1024'(s_do[31:16]),
                    1024'(sv[1] ? ref_s(rb, int'(r1)) : 16'h0000));
            end
        end

        // Default configuration: full-width random base, all 32 entries
        for (int w = 0; w < 32; w++) bb[w*32 +: 32] = $urandom;
        bb[1023:1020] = 4'h0;
        bb[1019]      = 1'b1;
        b_base = bb;
        b_load = 1'b1;
        step();
        b_load = 1'b0;
        n = 0;
        while (!b_ready && n < 80) begin
            step();
            n++;
        end
        chk("big_latency", 1024'(n), 1024'(32));
        chk("big_done", 1024'(b_done), 1024'(1));
        for (int k = 0; k < 32; k++) begin
            b_selv = 2'b11;
            b_sel  = {5'(31 - k), 5'(k)};
            step();
            chk("big_dv", 1024'(b_dv), 1024'(2'b11));
            chk("big_lane0", b_do[1023:0],    bb * 1024'(k));
            chk("big_lane1", b_do[2047:1024], bb * 1024'(31 - k));
        end
        b_sel = {5'd0, 5'd16};
        step();
        chk("big_entry16", b_do[1023:0], bb << 4);
        chk("big_entry0", b_do[2047:1024], 1024'(0));
        b_selv = 2'b00;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/xpb_lut_gen.md
Name: xpb_lut_gen

Overview:
- Runtime-generated, multi-lane successor to the fixed xpb constant tables used in the modular-square reduction path.
- A single WIDTH-bit base value is loaded once. The block then computes and stores all multiples k*base, for k = 0..2^SEL_W-1, by sequential accumulation.
- Once filled, it serves LANES independent registered lookups per cycle.
- This lets one RTL instance serve any modulus without regenerating hard-coded tables.

Parameters:
- WIDTH, 1024, bit width of base value and of each table entry.
- SEL_W, 5, select width; table depth is 2^SEL_W entries.
- LANES, 2, number of independent lookup channels.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load_valid  in  1  request to load base_in and regenerate the table.
- base_in  in  WIDTH  base value; sampled only when a load is accepted.
- busy  out  1  high while the table is being filled.
- ready  out  1  high when the table is complete and lookups are served.
- done  out  1  one-cycle pulse in the first cycle ready is high after a fill.
- overflow  out  1  sticky; set if any accumulation carried out of WIDTH during the current fill.
- sel_valid  in  LANES  per-lane lookup request.
- sel_in  in  LANES*SEL_W  per-lane index; lane i occupies bits [i*SEL_W +: SEL_W].
- data_valid  out  LANES  per-lane registered response valid.
- data_out  out  LANES*WIDTH  per-lane entry; lane i occupies bits [i*WIDTH +: WIDTH].

Behaviour:
- Reset (async assert, any state, including mid-fill):
  - state=IDLE; busy=0, ready=0, done=0, overflow=0.
  - data_valid=0, data_out=0; counter=0, accumulator=0.
  - Table storage is not reset; ready=0 gates all reads.
- States: IDLE, FILL, READY.
- IDLE: load_valid=1 at edge E0 → latch base_in, clear accumulator, counter and overflow; go to FILL (busy=1 after E0).
- FILL: at each edge Ek, k=1..2^SEL_W:
  - table[k-1] <= acc; acc <= acc + base (truncated mod 2^WIDTH).
  - overflow |= carry-out.
  - counter increments.
  - Entry 0 is always 0.
  - After edge E(2^SEL_W): state=READY, busy=0, ready=1, done=1 for exactly one cycle.
- Fill latency: ready rises 2^SEL_W cycles after the accepting edge E0.
- load_valid during FILL: ignored; no restart and no queueing.
- READY: load_valid=1 → behaves as in IDLE; ready drops after that edge.
- Lookup, per lane, independent:
  - If sel_valid[i]=1 and ready=1 at an edge: data_out lane i <= table[sel_in lane i] and data_valid[i] <= 1.
  - Otherwise data_valid[i] <= 0 and data_out lane i <= 0.
  - Latency is 1 cycle.
  - Lanes may select the same index simultaneously.
- Simultaneous load_valid and sel_valid in READY: the lookup at that edge is served from the old table with valid=1. From the next cycle ready=0, so requests are not served.
- Arithmetic: unsigned only; no modular reduction. Entries wrap mod 2^WIDTH and overflow flags that a wrap occurred.
- The table must be synthesisable as a register array or LUTRAM with LANES read ports and one write port.

Test Plan:
- WIDTH=16, SEL_W=3, LANES=2; reset, load base_in=0x0123 → busy for 8 cycles; ready and done rise after 8 cycles; done lasts 1 cycle; overflow=0. Lane0 sel=5 → 0x05AF; lane1 sel=7 → 0x07F5, both one cycle later.
- Same config, base_in=0x2500 → entry 6 = 0xDE00, entry 7 = 0x0300, overflow=1. A reload with 0x0001 clears overflow; entry 7 = 0x0007.
- Request lookups during FILL and a second load_valid mid-fill → data_valid=0, data_out=0; the second load is ignored; fill completes on the original schedule.
- In READY, assert load_valid (base 0x0002) together with sel=3 → that lookup returns old 3*base with valid=1. Ready drops next cycle, rises 8 cycles after the load edge; sel=3 then returns 0x0006.
- Assert rst_n low for part of a cycle at fill step 4 → all outputs 0 immediately. After release, no lookup is served until a new load completes.
- Default config (1024/5/2): load a random 1020-bit base → all 32 entries equal k*base; entry 16 equals base<<4; ready after 32 cycles.
